// File: rtl/pulse_period_meter.sv
// pulse_period_meter: measures rise-to-rise period and high time of sig_in in
// clk cycles. Each completed measurement is offered on a valid/ready output
// with a saturation flag; a result that cannot be delivered sets sticky overrun.
module pulse_period_meter #(
  parameter int CNT_W   = 8,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_sat,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] pcnt_nxt;
  logic [CNT_W-1:0] hcnt_nxt;
  logic             sat;
  logic             sat_nxt;
  logic             s;
  logic             s_d;
  logic             rise;
  logic             fall;
  logic             complete;

  // Increment that sticks at full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  generate
    if (SYNC_EN) begin : g_sync
      logic sync1;
      logic sync2;
      // Two-flop synchroniser for an asynchronous sig_in.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1 <= 1'b0;
          sync2 <= 1'b0;
        end else begin
          sync1 <= sig_in;
          sync2 <= sync1;
        end
      end
      assign s = sync2;
    end else begin : g_nosync
      assign s = sig_in;
    end
  endgenerate

  // Delayed copy of the synchronised signal for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s_d <= 1'b0;
    else        s_d <= s;
  end

  assign rise     = s & ~s_d;
  assign fall     = ~s & s_d;
  assign complete = rise && (state == LOW);

  // Next counter values; a rise restarts both counts at 1, high count freezes on the fall cycle.
  always_comb begin
    pcnt_nxt = pcnt;
    hcnt_nxt = hcnt;
    if (rise) begin
      pcnt_nxt = CNT_W'(1);
      hcnt_nxt = CNT_W'(1);
    end else begin
      case (state)
        HIGH: begin
          pcnt_nxt = sat_inc(pcnt);
          if (!fall) hcnt_nxt = sat_inc(hcnt);
        end
        LOW:     pcnt_nxt = sat_inc(pcnt);
        default: ;
      endcase
    end
    sat_nxt = rise ? 1'b0 : (sat | (pcnt_nxt == CNT_MAX) | (hcnt_nxt == CNT_MAX));
  end

  // FSM, counters and result handshake; clr overrides everything except the data fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pcnt        <= '0;
      hcnt        <= '0;
      sat         <= 1'b0;
      meas_period <= '0;
      meas_high   <= '0;
      meas_sat    <= 1'b0;
      meas_valid  <= 1'b0;
      overrun     <= 1'b0;
    end else if (clr) begin
      state      <= IDLE;
      pcnt       <= '0;
      hcnt       <= '0;
      sat        <= 1'b0;
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      pcnt <= pcnt_nxt;
      hcnt <= hcnt_nxt;
      sat  <= sat_nxt;
      case (state)
        IDLE:    if (rise) state <= HIGH;
        HIGH:    if (fall) state <= LOW;
        LOW:     if (rise) state <= HIGH;
        default: state <= IDLE;
      endcase
      if (complete) begin
        if (!meas_valid || meas_ready) begin
          meas_period <= pcnt;
          meas_high   <= hcnt;
          meas_sat    <= sat;
          meas_valid  <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Testbench for pulse_period_meter: table of high/low segment lengths with
// hand-computed results, randomized segments against an arithmetic model,
// and hand-written sequences for latency, overrun, clr and async reset.
module tb_pulse_period_meter;

  localparam int CNT_W = 8;
  localparam int MAXV  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sig_in = 1'b0;
  logic             clr = 1'b0;
  logic             ready = 1'b1;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_sat;
  logic             meas_valid;
  logic             overrun;

  typedef struct {
    int hi;
    int lo;
    int per;
    int hgh;
    int sat;
  } vec_t;

  vec_t tbl [10];
  vec_t exp_q [$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  pulse_period_meter #(.CNT_W(CNT_W), .SYNC_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sig_in      (sig_in),
    .clr         (clr),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .meas_sat    (meas_sat),
    .meas_valid  (meas_valid),
    .meas_ready  (ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a measurement is simply the segment durations, clipped at full scale.
  function automatic vec_t model(input int h, input int l);
    vec_t v;
    v.hi  = h;
    v.lo  = l;
    v.per = (h + l > MAXV) ? MAXV : h + l;
    v.hgh = (h > MAXV) ? MAXV : h;
    v.sat = (h + l >= MAXV) ? 1 : 0;
    return v;
  endfunction

  // Scoreboard: every delivered result must match the oldest expected one.
  always @(negedge clk) begin
    if (mon_en && rst_n && meas_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got period %0d high %0d, required no result", meas_period, meas_high);
      end else begin
        vec_t e;
        e = exp_q.pop_front();
        check("period", int'(meas_period), e.per);
        check("high",   int'(meas_high),   e.hgh);
        check("sat",    int'(meas_sat),    e.sat);
      end
    end
  end

  task automatic seg(input int h, input int l);
    sig_in = 1'b1;
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic start_section();
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic close_section();
    sig_in = 1'b1;
    repeat (2) @(negedge clk);
    sig_in = 1'b0;
    repeat (6) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("overrun_clear", int'(overrun), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8,   8,   16,  8,   0};
    tbl[1] = '{1,   1,   2,   1,   0};
    tbl[2] = '{1,   1,   2,   1,   0};
    tbl[3] = '{16,  16,  32,  16,  0};
    tbl[4] = '{300, 10,  255, 255, 1};
    tbl[5] = '{8,   8,   16,  8,   0};
    tbl[6] = '{3,   5,   8,   3,   0};
    tbl[7] = '{1,   253, 254, 1,   0};
    tbl[8] = '{1,   254, 255, 1,   1};
    tbl[9] = '{254, 1,   255, 254, 1};

    // Reset state
    #12;
    check("rst_valid",   int'(meas_valid),  0);
    check("rst_period",  int'(meas_period), 0);
    check("rst_high",    int'(meas_high),   0);
    check("rst_overrun", int'(overrun),     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven segments
    mon_en = 1'b1;
    start_section();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(tbl[i]);
      seg(tbl[i].hi, tbl[i].lo);
    end
    close_section();

    // Randomized segments against the model
    start_section();
    for (int i = 0; i < 40; i++) begin
      int h;
      int l;
      if (i % 9 == 4) begin
        h = $urandom_range(150, 300);
        l = $urandom_range(1, 120);
      end else begin
        h = $urandom_range(1, 40);
        l = $urandom_range(1, 40);
      end
      exp_q.push_back(model(h, l));
      seg(h, l);
    end
    close_section();

    // Latency: valid appears two edges after the edge that first samples the high
    mon_en = 1'b0;
    start_section();
    seg(3, 3);
    sig_in = 1'b1;
    @(negedge clk);
    check("lat_e0_valid", int'(meas_valid), 0);
    @(negedge clk);
    check("lat_e1_valid", int'(meas_valid), 0);
    @(negedge clk);
    check("lat_e2_valid", int'(meas_valid), 1);
    check("lat_period", int'(meas_period), 6);
    check("lat_high",   int'(meas_high),   3);
    @(negedge clk);
    check("lat_valid_drop", int'(meas_valid), 0);

    // Backpressure: second completion dropped, first held, overrun sticky until clr
    start_section();
    ready = 1'b0;
    seg(8, 8);
    seg(5, 5);
    sig_in = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_valid",   int'(meas_valid),  1);
    check("bp_period",  int'(meas_period), 16);
    check("bp_high",    int'(meas_high),   8);
    check("bp_sat",     int'(meas_sat),    0);
    check("bp_overrun", int'(overrun),     1);
    ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop",  int'(meas_valid), 0);
    check("bp_overrun_hold", int'(overrun),   1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_overrun", int'(overrun), 0);

    // Async reset mid-HIGH, then re-arm and measure
    sig_in = 1'b0;
    repeat (3) @(negedge clk);
    sig_in = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_rst_period", int'(meas_period), 16);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_period", int'(meas_period), 0);
    check("arst_high",   int'(meas_high),   0);
    check("arst_valid",  int'(meas_valid),  0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    sig_in = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.push_back('{3, 4, 7, 3, 0});
    close_section();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
